// File: rtl/fp_add_sequencer.sv
// Operand FIFO plus issue/capture FSM sitting in front of the fpAdder core.
// Holds add_enable for ADD_LATENCY cycles per pair and presents each sum on a valid/ready port.
module fp_add_sequencer #(
  parameter int DEPTH       = 4,
  parameter int ADD_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         op_valid,
  output logic                         op_ready,
  input  logic [31:0]                  op_a,
  input  logic [31:0]                  op_b,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [31:0]                  res_data,
  output logic                         res_overflow,
  output logic [31:0]                  add_in1,
  output logic [31:0]                  add_in2,
  output logic                         add_enable,
  input  logic [31:0]                  add_out,
  input  logic                         add_overflow,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic [7:0]                   ovf_count,
  output logic                         busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(ADD_LATENCY + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] lat_cnt;
  logic [63:0]   mem [DEPTH];
  logic          push;
  logic          pop;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign op_ready = !reset && (fifo_count < CW'(DEPTH));
  assign push     = op_valid && op_ready;
  assign pop      = (state == IDLE) && (fifo_count != '0);

  // Operand storage carries data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {op_a, op_b};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      add_in1      <= '0;
      add_in2      <= '0;
      add_enable   <= 1'b0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_overflow <= 1'b0;
      ovf_count    <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            add_in1 <= mem[rd_ptr][63:32];
            add_in2 <= mem[rd_ptr][31:0];
            busy    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          lat_cnt    <= LW'(ADD_LATENCY - 1);
          add_enable <= 1'b1;
          state      <= RUN;
        end
        RUN: begin
          // Sample the adder on the last enabled edge, so enable spans ADD_LATENCY cycles.
          if (lat_cnt == '0) begin
            res_data     <= add_out;
            res_overflow <= add_overflow;
            res_valid    <= 1'b1;
            add_enable   <= 1'b0;
            state        <= DONE;
          end else begin
            lat_cnt <= lat_cnt - LW'(1);
          end
        end
        default: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (res_overflow) ovf_count <= sat_inc(ovf_count);
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
